// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder-sharing arbiter: FSM state encoding and default widths.
package adder_share_arbiter_pkg;

    localparam int DEF_W   = 16;
    localparam int DEF_IDW = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gid,
    output logic            any
);

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        grant = '0;
        gid   = '0;
        any   = 1'b0;
        // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                gid      = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                gid      = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one registered W+1-bit adder among NREQ requesters with round-robin
// arbitration and valid/ready handshakes; results carry the issuing requester's ID.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = DEF_IDW,
    parameter int W    = DEF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W:0]        res_sum,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [IDW-1:0]  id_q;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid;
    logic            any;

    logic [W-1:0]    a_arr [NREQ];
    logic [W-1:0]    b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*W +: W];
        assign b_arr[i] = req_b[i*W +: W];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .gid   (gid),
        .any   (any)
    );

    // Ready is offered only while idle so no requester can be accepted mid-operation.
    assign req_ready = (state == ST_IDLE) ? grant : '0;

    // NOTE: sequential state uses non-blocking assignments only; operand registers are
    // reset as well so a result lost to reset can never leak into a later operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        a_q    <= a_arr[gid];
                        b_q    <= b_arr[gid];
                        id_q   <= gid;
                        rr_ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
                        busy   <= 1'b1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    res_sum   <= {1'b0, a_q} + {1'b0, b_q};
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: table of single operations plus
// hand-written fairness, backpressure, skip/rotate and reset sequences.
module tb_adder_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] a_in [4];
    logic [15:0] b_in [4];
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [16:0] res_sum;
    logic [1:0]  res_id;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign req_a = {a_in[3], a_in[2], a_in[1], a_in[0]};
    assign req_b = {b_in[3], b_in[2], b_in[1], b_in[0]};

    adder_share_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy)
    );

    typedef struct {
        logic [1:0]  id;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] sum;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant vector must be one-hot or zero on every cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            vectors++;
            if (!$onehot0(req_ready)) begin
                errors++;
                $display("FAIL ready_onehot0: got 0x%0h expected one-hot or zero at %0t", req_ready, $time);
            end
        end
    end

    // Starts at a falling edge with the DUT idle; ends at a falling edge with it idle again.
    task automatic do_op(input logic [1:0] id, input logic [15:0] a, input logic [15:0] b,
                         input logic [16:0] exp_sum);
        req_valid = 4'b0001 << id;
        a_in[id]  = a;
        b_in[id]  = b;
        res_ready = 1'b1;
        #1;
        check("op_req_ready", 32'(req_ready), 32'(4'b0001 << id));
        @(negedge clk);
        req_valid = 4'b0000;
        check("op_calc_res_valid", 32'(res_valid), 32'd0);
        check("op_calc_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("op_done_res_valid", 32'(res_valid), 32'd1);
        check("op_done_sum", 32'(res_sum), 32'(exp_sum));
        check("op_done_id", 32'(res_id), 32'(id));
        @(negedge clk);
        check("op_idle_res_valid", 32'(res_valid), 32'd0);
        check("op_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        tbl[0] = '{2'd1, 16'h1234, 16'h0F0F, 17'h02143};
        tbl[1] = '{2'd0, 16'hFFFF, 16'h0001, 17'h10000};
        tbl[2] = '{2'd2, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
        tbl[3] = '{2'd3, 16'h0000, 16'h0000, 17'h00000};
        tbl[4] = '{2'd1, 16'h8000, 16'h8000, 17'h10000};
        tbl[5] = '{2'd0, 16'h0001, 16'h0002, 17'h00003};

        rst       = 1'b1;
        req_valid = 4'b0000;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_sum", 32'(res_sum), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fairness: all four valid continuously, grants rotate from 0.
        a_in[0] = 16'h0001; b_in[0] = 16'h0002;
        a_in[1] = 16'h1234; b_in[1] = 16'h4321;
        a_in[2] = 16'hFFFF; b_in[2] = 16'h0001;
        a_in[3] = 16'h8000; b_in[3] = 16'h7FFF;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [16:0] fair_exp [4];
            fair_exp[0] = 17'h00003;
            fair_exp[1] = 17'h05555;
            fair_exp[2] = 17'h10000;
            fair_exp[3] = 17'h0FFFF;
            #1;
            check("fair_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            @(negedge clk);
            check("fair_calc_res_valid", 32'(res_valid), 32'd0);
            @(negedge clk);
            check("fair_res_valid", 32'(res_valid), 32'd1);
            check("fair_res_id", 32'(res_id), 32'(k % 4));
            check("fair_res_sum", 32'(res_sum), 32'(fair_exp[k % 4]));
            @(negedge clk);
        end
        req_valid = 4'b0000;
        @(negedge clk);

        for (int v = 0; v < 6; v++)
            do_op(tbl[v].id, tbl[v].a, tbl[v].b, tbl[v].sum);

        // Backpressure: consumer stalls 10 cycles while other requesters wait.
        req_valid = 4'b0100;
        a_in[2]   = 16'hABCD;
        b_in[2]   = 16'h1111;
        res_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b1011;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_sum", 32'(res_sum), 32'h0BCDE);
            check("bp_res_id", 32'(res_id), 32'd2);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("bp_release_res_valid", 32'(res_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);

        // Skip and rotate: pointer moved to 2 by a grant to req 1, then 0 and 3 compete.
        do_op(2'd1, 16'h0010, 16'h0020, 17'h00030);
        a_in[0] = 16'h0100; b_in[0] = 16'h0200;
        a_in[3] = 16'h3000; b_in[3] = 16'h0003;
        req_valid = 4'b1001;
        #1;
        check("skip_first_grant", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = 4'b0001;
        @(negedge clk);
        check("skip_first_id", 32'(res_id), 32'd3);
        check("skip_first_sum", 32'(res_sum), 32'h03003);
        @(negedge clk);
        #1;
        check("skip_second_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        check("skip_second_id", 32'(res_id), 32'd0);
        check("skip_second_sum", 32'(res_sum), 32'h00300);
        @(negedge clk);

        // Reset mid-CALC: result lost, pointer back to 0.
        req_valid = 4'b0100;
        a_in[2]   = 16'h5555;
        b_in[2]   = 16'h5555;
        @(negedge clk);
        req_valid = 4'b0000;
        check("midrst_in_calc_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_res_sum", 32'(res_sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_result", 32'(res_valid), 32'd0);
        req_valid = 4'b1111;
        #1;
        check("midrst_next_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        check("midrst_after_id", 32'(res_id), 32'd0);
        check("midrst_after_sum", 32'(res_sum), 32'h00300);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
